haar_stage_sequencer: RTL and testbench

Sequences Haar-cascade evaluation of one detection window. It walks stages 0..NUM_STAGES-1 and, for each stage, issues that stage's feature-ROM addresses one per handshake to the feature evaluator. It then waits for the evaluator's stage verdict and either advances to the next stage or exits early on a reject. It sits between the window scanner, which starts it, the per-stage feature-count table, and the feature ROM/evaluator datapath.

---
 rtl/haar_stage_sequencer.sv | 159 +++++++++++++++
 tb/tb_haar_stage_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/haar_stage_sequencer.sv
// haar_stage_sequencer
// ---------------------------------------------------------------------------
// Walks the stages of a Haar cascade for one detection window. For each
// stage it reads the feature count from the count table, streams that many
// feature-ROM addresses to the evaluator, then waits for the stage verdict.
// A failed stage ends the window at once. Passing the last stage reports a
// detected face.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_start               start a window (only looked at in IDLE)
//   o_stage_index         current stage, addresses the count table
//   i_stage_count         feature count for o_stage_index (one cycle later)
//   o_feature_address     flat feature-ROM address, contiguous over stages
//   o_feature_valid       address valid
//   i_feature_ready       evaluator accepts the address
//   o_stage_last          marks the final feature of the current stage
//   i_stage_result_valid  verdict strobe from the evaluator
//   i_stage_pass          verdict, 1 = stage passed
//   o_busy                high whenever the sequencer is not idle
//   o_done                one-cycle pulse at the end of a window
//   o_face_detected       outcome of the last window, held until next start
//   o_dbg_state           current FSM state (debug)
//
// Feature stream handshake: an address transfers on a rising edge where
// o_feature_valid and i_feature_ready are both high. Once valid is raised,
// valid, address and last stay constant until that transfer happens; valid
// never depends on ready.
//
// Every output is a register or a decode of registered state, so there is
// no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module haar_stage_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNT_WIDTH = 8,
  parameter int STAGE_WIDTH = 5,
  parameter int NUM_STAGES  = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  output logic [STAGE_WIDTH-1:0] o_stage_index,
  input  logic [COUNT_WIDTH-1:0] i_stage_count,
  output logic [ADDR_WIDTH-1:0]  o_feature_address,
  output logic                   o_feature_valid,
  input  logic                   i_feature_ready,
  output logic                   o_stage_last,
  input  logic                   i_stage_result_valid,
  input  logic                   i_stage_pass,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_face_detected,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);

  state_t                 state_q;
  logic [STAGE_WIDTH-1:0] stage_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] feat_cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_max_q;
  logic                   detected_q;
  logic                   is_last_feat;

  // cnt_max_q is never zero while in FETCH, so the subtraction cannot wrap
  // into a false match there.
  assign is_last_feat = (feat_cnt_q == cnt_max_q - COUNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      addr_q     <= '0;
      feat_cnt_q <= '0;
      cnt_max_q  <= '0;
      detected_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            stage_q    <= '0;
            addr_q     <= '0;
            feat_cnt_q <= '0;
            detected_q <= 1'b0;
            state_q    <= S_LOAD;
          end
        end

        S_LOAD: begin
          cnt_max_q  <= i_stage_count;
          feat_cnt_q <= '0;
          if (i_stage_count == '0) begin
            // An empty stage passes trivially; no features, no verdict.
            if (stage_q == LAST_STAGE) begin
              detected_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              stage_q <= stage_q + STAGE_WIDTH'(1);
            end
          end else begin
            state_q <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (i_feature_ready) begin
            // Address wraps silently; the cascade size is sized by the user.
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            feat_cnt_q <= feat_cnt_q + COUNT_WIDTH'(1);
            if (is_last_feat) begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (i_stage_result_valid) begin
            if (!i_stage_pass) begin
              detected_q <= 1'b0;
              state_q    <= S_DONE;
            end else if (stage_q == LAST_STAGE) begin
              detected_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              stage_q <= stage_q + STAGE_WIDTH'(1);
              state_q <= S_LOAD;
            end
          end
        end

        S_DONE: begin
          // A start arriving here is dropped; only IDLE accepts it.
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_stage_index     = stage_q;
  assign o_feature_address = addr_q;
  assign o_feature_valid   = (state_q == S_FETCH);
  assign o_stage_last      = (state_q == S_FETCH) && is_last_feat;
  assign o_busy            = (state_q != S_IDLE);
  assign o_done            = (state_q == S_DONE);
  assign o_face_detected   = detected_q;
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// Bench for haar_stage_sequencer: three-stage cascade, 3-bit addresses so
// the address wrap is reachable. A per-window model builds the expected
// address stream, stage boundaries and outcome from the counts and verdicts.
module tb_haar_stage_sequencer;

  localparam int AW = 3;
  localparam int CW = 8;
  localparam int SW = 5;
  localparam int NS = 3;
  localparam int W  = SW + 1 + AW;   // {stage, last, address}

  logic          clk;
  logic          reset;
  logic          i_start;
  logic [SW-1:0] o_stage_index;
  logic [CW-1:0] i_stage_count;
  logic [AW-1:0] o_feature_address;
  logic          o_feature_valid;
  logic          i_feature_ready;
  logic          o_stage_last;
  logic          i_stage_result_valid;
  logic          i_stage_pass;
  logic          o_busy;
  logic          o_done;
  logic          o_face_detected;
  logic [2:0]    o_dbg_state;

  logic [CW-1:0] cnt_tab [32];
  logic [W-1:0]  exp_q [$];
  int            n_vec;
  int            n_bad;

  // Count table with the one-cycle lookup: index registered in the DUT,
  // count available in the cycle after the index changes.
  assign i_stage_count = cnt_tab[o_stage_index];

  haar_stage_sequencer #(
    .ADDR_WIDTH (AW),
    .COUNT_WIDTH(CW),
    .STAGE_WIDTH(SW),
    .NUM_STAGES (NS)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_start             (i_start),
    .o_stage_index       (o_stage_index),
    .i_stage_count       (i_stage_count),
    .o_feature_address   (o_feature_address),
    .o_feature_valid     (o_feature_valid),
    .i_feature_ready     (i_feature_ready),
    .o_stage_last        (o_stage_last),
    .i_stage_result_valid(i_stage_result_valid),
    .i_stage_pass        (i_stage_pass),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_face_detected     (o_face_detected),
    .o_dbg_state         (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, o_dbg_state, 0);
    check({tag, "_stage"}, o_stage_index, 0);
    check({tag, "_addr"}, o_feature_address, 0);
    check({tag, "_valid"}, o_feature_valid, 0);
    check({tag, "_last"}, o_stage_last, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_det"}, o_face_detected, 0);
  endtask

  // ---------------- driver + model ----------------
  // rmode: 0 ready always high, 1 random ready, 2 pattern 1,0,0,1 in stage 1.
  task automatic run_window(input int c0, input int c1, input int c2,
                            input bit v0, input bit v1, input bit v2,
                            input int rmode, input bit strays);
    int          cnt [3];
    bit          ver [3];
    bit          pat [4];
    logic [AW-1:0] a;
    logic [W-1:0]  e;
    bit          exp_det;
    int          fin_stage;
    bit          by_verdict;
    int          exp_hs;
    int          hs;
    int          vcount;
    int          cyc;
    int          verdict_cyc;
    int          cur_stage;
    int          rk;
    bit          prev_hold;
    logic [AW-1:0] prev_addr;
    logic        prev_last;
    bit          done_seen;

    cnt = '{c0, c1, c2};
    ver = '{v0, v1, v2};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 32; s++) cnt_tab[s] = '0;
    cnt_tab[0] = c0[CW-1:0];
    cnt_tab[1] = c1[CW-1:0];
    cnt_tab[2] = c2[CW-1:0];

    // Model: addresses run contiguously from 0 (mod 2^AW) through the
    // stages until a failing verdict; empty stages contribute nothing.
    exp_q.delete();
    a          = '0;
    exp_det    = 1'b1;
    fin_stage  = NS - 1;
    by_verdict = (c2 != 0);
    exp_hs     = 0;
    for (int s = 0; s < NS; s++) begin
      if (cnt[s] == 0) continue;
      for (int k = 0; k < cnt[s]; k++) begin
        e = {SW'(s), (k == cnt[s] - 1), a};
        exp_q.push_back(e);
        a = a + 1'b1;
        exp_hs++;
      end
      if (!ver[s]) begin
        exp_det    = 1'b0;
        fin_stage  = s;
        by_verdict = 1'b1;
        break;
      end
    end

    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("load_busy", o_busy, 1);
    check("load_valid", o_feature_valid, 0);

    vcount      = 0;
    cyc         = 0;
    verdict_cyc = -10;
    cur_stage   = 0;
    hs          = 0;
    rk          = 0;
    prev_hold   = 1'b0;
    prev_addr   = '0;
    prev_last   = 1'b0;
    done_seen   = 1'b0;
    i_feature_ready = 1'b1;

    while (!done_seen && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      i_stage_result_valid = 1'b0;
      i_start              = 1'b0;

      if (prev_hold) begin
        check("hold_valid", o_feature_valid, 1);
        check("hold_addr", o_feature_address, prev_addr);
        check("hold_last", o_stage_last, prev_last);
      end

      if (o_done) begin
        done_seen = 1'b1;
        check("det", o_face_detected, exp_det);
        check("fin_stage", o_stage_index, fin_stage);
        check("hs_total", hs, exp_hs);
        check("exp_left", exp_q.size(), 0);
        if (by_verdict) check("done_lat", cyc - verdict_cyc, 1);
      end

      if (vcount > 0) begin
        vcount--;
        if (vcount == 0) begin
          i_stage_result_valid = 1'b1;
          i_stage_pass         = ver[cur_stage];
          verdict_cyc          = cyc;
        end
      end

      case (rmode)
        0: i_feature_ready = 1'b1;
        1: i_feature_ready = 1'($urandom_range(0, 1));
        default: begin
          if (o_feature_valid && o_stage_index == 1) begin
            i_feature_ready = pat[rk % 4];
            rk++;
          end else begin
            i_feature_ready = 1'b1;
          end
        end
      endcase

      // Stray start / verdict while streaming; both must be ignored.
      if (strays && o_feature_valid && $urandom_range(0, 2) == 0) begin
        i_start = 1'b1;
        if (!i_stage_result_valid) begin
          i_stage_result_valid = 1'b1;
          i_stage_pass         = 1'($urandom_range(0, 1));
        end
      end

      if (o_feature_valid && i_feature_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          check("extra_hs", hs, exp_hs);
        end else begin
          e = exp_q.pop_front();
          check("addr", o_feature_address, e[AW-1:0]);
          check("last", o_stage_last, e[AW]);
          check("stage", o_stage_index, e[W-1:AW+1]);
          if (e[AW]) begin
            cur_stage = int'(e[W-1:AW+1]);
            vcount    = $urandom_range(1, 3);
          end
        end
      end

      prev_hold = o_feature_valid && !i_feature_ready;
      prev_addr = o_feature_address;
      prev_last = o_stage_last;
    end
    check("done_seen", done_seen, 1);

    i_start              = 1'b0;
    i_stage_result_valid = 1'b0;
    @(negedge clk);
    check("done_pulse", o_done, 0);
    check("busy_after", o_busy, 0);
    check("det_hold", o_face_detected, exp_det);
  endtask

  // Reset while stage 1 is streaming; outputs must clear, no o_done.
  task automatic reset_mid_window();
    bit reached;
    reached = 1'b0;
    for (int s = 0; s < 32; s++) cnt_tab[s] = '0;
    cnt_tab[0] = 8'd2;
    cnt_tab[1] = 8'd3;
    cnt_tab[2] = 8'd1;
    i_feature_ready      = 1'b1;
    // Verdict held high: ignored outside WAIT_RESULT, a pass inside it.
    i_stage_result_valid = 1'b1;
    i_stage_pass         = 1'b1;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (o_feature_valid && o_stage_index == 1) reached = 1'b1;
    end
    check("rst_reach_stage1", reached, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    i_stage_result_valid = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_done", o_done, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec                = 0;
    n_bad                = 0;
    reset                = 1'b1;
    i_start              = 1'b0;
    i_feature_ready      = 1'b1;
    i_stage_result_valid = 1'b0;
    i_stage_pass         = 1'b0;
    for (int s = 0; s < 32; s++) cnt_tab[s] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    run_window(2, 3, 1, 1, 1, 1, 0, 0);   // all stages pass
    run_window(2, 3, 1, 1, 0, 1, 0, 0);   // reject at stage 1
    run_window(2, 3, 1, 1, 1, 1, 2, 0);   // backpressure in stage 1
    run_window(2, 0, 1, 1, 1, 1, 0, 0);   // empty middle stage
    run_window(2, 3, 1, 1, 1, 1, 0, 1);   // stray start / verdict while streaming
    reset_mid_window();
    run_window(2, 3, 1, 1, 1, 1, 0, 0);   // restart from address 0
    run_window(5, 5, 1, 1, 1, 1, 0, 0);   // address wrap
    run_window(1, 2, 0, 1, 1, 1, 1, 0);   // empty last stage

    for (int t = 0; t < 30; t++) begin
      run_window($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), 1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
